// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs long-latency unit,
// with a per-register busy scoreboard, starvation request and protocol flag.
module rf_wb_arbiter #(
  parameter int unsigned WAIT_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        p_we,
  input  logic [4:0]  p_wn,
  input  logic [31:0] p_d,
  input  logic        m_valid,
  input  logic [4:0]  m_wn,
  input  logic [31:0] m_d,
  output logic        m_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wn,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        starve,
  output logic        proto_err,
  output logic        rf_we,
  output logic [4:0]  rf_wn,
  output logic [31:0] rf_d
);

  typedef enum logic {
    SRC_P = 1'b0,
    SRC_M = 1'b1
  } src_e;

  localparam logic [CNT_W-1:0] WMAX = CNT_W'(WAIT_MAX);

  logic             p_act;
  logic             m_acc;
  logic             m_wr;
  logic             iss_set;
  logic             clr_m;
  logic             err_d;
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rf_we_q;
  logic [4:0]       rf_wn_q;
  logic [31:0]      rf_d_q;
  src_e             src_q;
  logic             starve_q;
  logic             perr_q;

  assign p_act   = p_we && (p_wn != 5'd0);
  assign m_ready = !p_act || !clrn;
  assign m_acc   = m_valid && !p_act;
  assign m_wr    = m_acc && (m_wn != 5'd0);
  assign iss_set = iss_valid && (iss_wn != 5'd0);
  // A long-latency result retires its busy bit as it commits to the RF
  assign clr_m   = rf_we_q && (src_q == SRC_M);

  always_comb begin
    busy_d = busy_q;
    if (clr_m)   busy_d[rf_wn_q] = 1'b0;
    if (iss_set) busy_d[iss_wn]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    err_d = 1'b0;
    if (iss_set && busy_q[iss_wn] &&
        !(clr_m && (rf_wn_q == iss_wn)))
      err_d = 1'b1;
    if (p_act && busy_q[p_wn])
      err_d = 1'b1;
    if (m_wr && !busy_q[m_wn])
      err_d = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!m_valid || m_acc)
      cnt_d = '0;
    else if (cnt_q != WMAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rf_we_q  <= 1'b0;
      rf_wn_q  <= 5'd0;
      rf_d_q   <= 32'd0;
      src_q    <= SRC_P;
      busy_q   <= 32'd0;
      cnt_q    <= '0;
      starve_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      rf_we_q <= p_act || m_wr;
      if (p_act) begin
        rf_wn_q <= p_wn;
        rf_d_q  <= p_d;
        src_q   <= SRC_P;
      end else if (m_wr) begin
        rf_wn_q <= m_wn;
        rf_d_q  <= m_d;
        src_q   <= SRC_M;
      end
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      starve_q <= (cnt_d == WMAX);
      perr_q   <= perr_q || err_d;
    end
  end

  assign rs_busy   = busy_q[rs];
  assign rt_busy   = busy_q[rt];
  assign starve    = starve_q;
  assign proto_err = perr_q;
  assign rf_we     = rf_we_q;
  assign rf_wn     = rf_wn_q;
  assign rf_d      = rf_d_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed plus randomized bench for rf_wb_arbiter against a
// cycle-level reference model of the write port and scoreboard.
module tb_rf_wb_arbiter;

  localparam int WMAX = 8;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        p_we = 1'b0;
  logic [4:0]  p_wn = '0;
  logic [31:0] p_d = '0;
  logic        m_valid = 1'b0;
  logic [4:0]  m_wn = '0;
  logic [31:0] m_d = '0;
  logic        m_ready;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_wn = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic        rs_busy, rt_busy, starve, proto_err;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;

  rf_wb_arbiter #(.WAIT_MAX(WMAX), .CNT_W(8)) dut (
    .clk(clk), .clrn(clrn),
    .p_we(p_we), .p_wn(p_wn), .p_d(p_d),
    .m_valid(m_valid), .m_wn(m_wn), .m_d(m_d), .m_ready(m_ready),
    .iss_valid(iss_valid), .iss_wn(iss_wn),
    .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .starve(starve), .proto_err(proto_err),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  bit          mb[32];
  bit          mwe, msrc_m, mstarve, mperr;
  logic [4:0]  mwn;
  logic [31:0] md;
  int          mcnt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    foreach (mb[i]) mb[i] = 1'b0;
    mwe = 0; msrc_m = 0; mstarve = 0; mperr = 0;
    mwn = '0; md = '0; mcnt = 0;
  endtask

  task automatic mdl_edge();
    bit pa, acc, clr;
    logic [4:0] cw;
    pa  = p_we && (p_wn != 0);
    acc = m_valid && !pa;
    clr = mwe && msrc_m;
    cw  = mwn;
    if (iss_valid && iss_wn != 0 && mb[iss_wn] && !(clr && cw == iss_wn))
      mperr = 1;
    if (pa && mb[p_wn]) mperr = 1;
    if (acc && m_wn != 0 && !mb[m_wn]) mperr = 1;
    if (clr) mb[cw] = 0;
    if (iss_valid && iss_wn != 0) mb[iss_wn] = 1;
    if (pa) begin
      mwe = 1; mwn = p_wn; md = p_d; msrc_m = 0;
    end else if (acc && m_wn != 0) begin
      mwe = 1; mwn = m_wn; md = m_d; msrc_m = 1;
    end else
      mwe = 0;
    if (!m_valid || acc) mcnt = 0;
    else if (mcnt < WMAX) mcnt++;
    mstarve = (mcnt == WMAX);
  endtask

  task automatic step();
    #1;
    chk("m_ready", m_ready, !(p_we && p_wn != 0));
    chk("rs_busy", rs_busy, mb[rs]);
    chk("rt_busy", rt_busy, mb[rt]);
    @(posedge clk);
    mdl_edge();
    #1;
    chk("rf_we", rf_we, mwe);
    chk("rf_wn", rf_wn, mwn);
    chk("rf_d", rf_d, md);
    chk("starve", starve, mstarve);
    chk("proto_err", proto_err, mperr);
    @(negedge clk);
  endtask

  task automatic drv(bit pwe, logic [4:0] pwn, logic [31:0] pd,
                     bit mv, logic [4:0] mw, logic [31:0] mdat,
                     bit iv, logic [4:0] iw);
    p_we = pwe; p_wn = pwn; p_d = pd;
    m_valid = mv; m_wn = mw; m_d = mdat;
    iss_valid = iv; iss_wn = iw;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_wn", rf_wn, 0);
    chk("rst_rf_d", rf_d, 0);
    chk("rst_starve", starve, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_m_ready", m_ready, 1);
    chk("rst_rs_busy", rs_busy, 0);
    mdl_clear();
    @(negedge clk);
    clrn = 1'b1;
  endtask

  initial begin
    logic [4:0] q[$];
    bit acc;
    int r;
    mdl_clear();
    do_reset();

    // long-latency write with idle pipeline
    drv(0, 0, 0, 0, 0, 0, 1, 5); step();
    drv(0, 0, 0, 1, 5, 32'hA5A5A5A5, 0, 0); step();
    chk("t1_wn", rf_wn, 5);
    chk("t1_d", rf_d, 32'hA5A5A5A5);

    // pipeline priority, m held until accepted
    drv(0, 0, 0, 0, 0, 0, 1, 7); step();
    drv(1, 3, 32'h11, 1, 7, 32'h77, 0, 0); step();
    chk("t2_p_wn", rf_wn, 3);
    drv(0, 0, 0, 1, 7, 32'h77, 0, 0); step();
    chk("t2_m_wn", rf_wn, 7);
    chk("t2_perr", proto_err, 0);

    // scoreboard lifetime of reg 9
    rs = 9; rt = 0;
    drv(0, 0, 0, 0, 0, 0, 1, 9); step();
    chk("t3_busy", rs_busy, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0); step();
    drv(0, 0, 0, 1, 9, 32'h99, 0, 0); step();
    chk("t3_still", rs_busy, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t3_clr", rs_busy, 0);
    chk("t3_rt", rt_busy, 0);

    // starvation
    drv(0, 0, 0, 0, 0, 0, 1, 6); step();
    for (int i = 0; i < WMAX; i++) begin
      drv(1, 3, i, 1, 6, 32'h66, 0, 0); step();
    end
    chk("t4_starve", starve, 1);
    drv(0, 0, 0, 1, 6, 32'h66, 0, 0); step();
    chk("t4_unstarve", starve, 0);
    chk("t4_wn", rf_wn, 6);

    // double issue
    do_reset();
    drv(0, 0, 0, 0, 0, 0, 1, 4); step();
    drv(0, 0, 0, 0, 0, 0, 1, 4); step();
    chk("t5_dbl", proto_err, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t5_sticky", proto_err, 1);

    // unsolicited result
    do_reset();
    drv(0, 0, 0, 1, 12, 32'hC, 0, 0); step();
    chk("t6_unsol", proto_err, 1);

    // write to r0 is a no-op
    do_reset();
    drv(1, 0, 32'hDEAD, 0, 0, 0, 0, 0); step();
    chk("t7_we", rf_we, 0);

    // mid-stream reset
    rs = 4;
    drv(0, 0, 0, 0, 0, 0, 1, 4); step();
    drv(0, 0, 0, 1, 4, 32'h44, 0, 0); step();
    chk("t8_we", rf_we, 1);
    drv(1, 2, 0, 0, 0, 0, 0, 0);
    do_reset();
    drv(0, 0, 0, 1, 4, 32'h44, 0, 0); step();
    chk("t8_perr", proto_err, 1);

    // randomized legal traffic
    do_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      iss_valid = 0;
      p_we = 0;
      if (!m_valid && q.size() > 0 && $urandom_range(0, 2) == 0) begin
        m_valid = 1; m_wn = q[0]; m_d = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 31);
        p_we = 1; p_wn = mb[r] ? 5'd0 : 5'(r); p_d = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(1, 31);
        if (!mb[r]) begin
          iss_valid = 1; iss_wn = 5'(r); q.push_back(5'(r));
        end
      end
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      acc = m_valid && !(p_we && p_wn != 0);
      step();
      if (acc) begin
        void'(q.pop_front());
        m_valid = 0;
      end
    end
    chk("rand_perr", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
